// File: rtl/controle_ula.sv
// ALU control sequencer: accepts one MIPS instruction, decodes it, drives the
// external ALU for ESPERA_ULA cycles, then holds the response until it is accepted.
module controle_ula #(
  parameter int unsigned ESPERA_ULA = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valido,
  output logic        instr_pronto,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  input  logic [15:0] imediato,
  output logic [31:0] ulaEntrada1,
  output logic [31:0] ulaEntrada2,
  output logic [3:0]  ulaControle,
  input  logic [31:0] ulaSaida,
  input  logic        ulaZero,
  output logic [31:0] resultado,
  output logic        desvio,
  output logic        erro,
  output logic        resultado_valido,
  input  logic        resultado_aceito
);

  typedef enum logic [1:0] {
    OCIOSO,
    DECODIFICA,
    EXECUTA,
    RESPONDE
  } estado_e;

  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0011;
  localparam logic [3:0] ULA_SLT = 4'b0100;
  localparam logic [3:0] ULA_NOR = 4'b0101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  estado_e     estado_q, estado_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [5:0]  funct_q, funct_d;
  logic [31:0] reg_a_q, reg_a_d;
  logic [31:0] reg_b_q, reg_b_d;
  logic [15:0] imediato_q, imediato_d;
  logic [3:0]  ula_controle_q, ula_controle_d;
  logic [31:0] ula_entrada1_q, ula_entrada1_d;
  logic [31:0] ula_entrada2_q, ula_entrada2_d;
  logic [3:0]  contador_q, contador_d;
  logic [31:0] resultado_q, resultado_d;
  logic        desvio_q, desvio_d;
  logic        erro_q, erro_d;

  logic        dec_legal;
  logic [3:0]  dec_controle;
  logic [31:0] dec_operando2;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign imm_sext = {{16{imediato_q[15]}}, imediato_q};
  assign imm_zext = {16'h0000, imediato_q};

  // Decode works on the captured fields, so the input bus may change after the handshake.
  always_comb begin
    dec_legal     = 1'b1;
    dec_controle  = ULA_ADD;
    dec_operando2 = reg_b_q;
    unique case (opcode_q)
      OP_RTYPE: begin
        unique case (funct_q)
          FN_ADD:  dec_controle = ULA_ADD;
          FN_SUB:  dec_controle = ULA_SUB;
          FN_AND:  dec_controle = ULA_AND;
          FN_OR:   dec_controle = ULA_OR;
          FN_SLT:  dec_controle = ULA_SLT;
          FN_NOR:  dec_controle = ULA_NOR;
          default: dec_legal    = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec_controle  = ULA_ADD;
        dec_operando2 = imm_sext;
      end
      OP_SLTI: begin
        dec_controle  = ULA_SLT;
        dec_operando2 = imm_sext;
      end
      OP_ANDI: begin
        dec_controle  = ULA_AND;
        dec_operando2 = imm_zext;
      end
      OP_ORI: begin
        dec_controle  = ULA_OR;
        dec_operando2 = imm_zext;
      end
      OP_LW, OP_SW: begin
        dec_controle  = ULA_ADD;
        dec_operando2 = imm_sext;
      end
      OP_BEQ, OP_BNE: begin
        dec_controle  = ULA_SUB;
        dec_operando2 = reg_b_q;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    estado_d       = estado_q;
    opcode_d       = opcode_q;
    funct_d        = funct_q;
    reg_a_d        = reg_a_q;
    reg_b_d        = reg_b_q;
    imediato_d     = imediato_q;
    ula_controle_d = ula_controle_q;
    ula_entrada1_d = ula_entrada1_q;
    ula_entrada2_d = ula_entrada2_q;
    contador_d     = contador_q;
    resultado_d    = resultado_q;
    desvio_d       = desvio_q;
    erro_d         = erro_q;

    unique case (estado_q)
      OCIOSO: begin
        if (instr_valido) begin
          opcode_d   = opcode;
          funct_d    = funct;
          reg_a_d    = regA;
          reg_b_d    = regB;
          imediato_d = imediato;
          estado_d   = DECODIFICA;
        end
      end
      DECODIFICA: begin
        if (dec_legal) begin
          ula_controle_d = dec_controle;
          ula_entrada1_d = reg_a_q;
          ula_entrada2_d = dec_operando2;
          contador_d     = 4'(ESPERA_ULA);
          estado_d       = EXECUTA;
        end else begin
          resultado_d = '0;
          desvio_d    = 1'b0;
          erro_d      = 1'b1;
          estado_d    = RESPONDE;
        end
      end
      EXECUTA: begin
        contador_d = contador_q - 4'd1;
        // <= guards against a zero count ever stalling the FSM.
        if (contador_q <= 4'd1) begin
          contador_d  = '0;
          resultado_d = ulaSaida;
          erro_d      = 1'b0;
          desvio_d    = (opcode_q == OP_BEQ) ? ulaZero  :
                        (opcode_q == OP_BNE) ? !ulaZero : 1'b0;
          estado_d    = RESPONDE;
        end
      end
      RESPONDE: begin
        if (resultado_aceito) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      opcode_q       <= '0;
      funct_q        <= '0;
      reg_a_q        <= '0;
      reg_b_q        <= '0;
      imediato_q     <= '0;
      ula_controle_q <= '0;
      ula_entrada1_q <= '0;
      ula_entrada2_q <= '0;
      contador_q     <= '0;
      resultado_q    <= '0;
      desvio_q       <= 1'b0;
      erro_q         <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      opcode_q       <= opcode_d;
      funct_q        <= funct_d;
      reg_a_q        <= reg_a_d;
      reg_b_q        <= reg_b_d;
      imediato_q     <= imediato_d;
      ula_controle_q <= ula_controle_d;
      ula_entrada1_q <= ula_entrada1_d;
      ula_entrada2_q <= ula_entrada2_d;
      contador_q     <= contador_d;
      resultado_q    <= resultado_d;
      desvio_q       <= desvio_d;
      erro_q         <= erro_d;
    end
  end

  assign instr_pronto     = (estado_q == OCIOSO);
  assign resultado_valido = (estado_q == RESPONDE);
  assign ulaControle      = ula_controle_q;
  assign ulaEntrada1      = ula_entrada1_q;
  assign ulaEntrada2      = ula_entrada2_q;
  assign resultado        = resultado_q;
  assign desvio           = desvio_q;
  assign erro             = erro_q;

endmodule

// File: tb/tb_controle_ula.sv
// Scoreboard bench for controle_ula: a behavioural ALU feeds both instances,
// expected responses are queued at issue and compared when resultado_valido rises.
module tb_controle_ula;

  localparam int unsigned ESP  = 1;
  localparam int unsigned ESP3 = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance with ESPERA_ULA = 1
  logic        reset, instr_valido, instr_pronto;
  logic [5:0]  opcode, funct;
  logic [31:0] regA, regB;
  logic [15:0] imediato;
  logic [31:0] ulaEntrada1, ulaEntrada2, ulaSaida, resultado;
  logic [3:0]  ulaControle;
  logic        ulaZero, desvio, erro, resultado_valido, resultado_aceito;

  // Instance with ESPERA_ULA = 3
  logic        reset_3, instr_valido_3, instr_pronto_3;
  logic [5:0]  opcode_3, funct_3;
  logic [31:0] regA_3, regB_3;
  logic [15:0] imediato_3;
  logic [31:0] ulaEntrada1_3, ulaEntrada2_3, ulaSaida_3, resultado_3;
  logic [3:0]  ulaControle_3;
  logic        ulaZero_3, desvio_3, erro_3, resultado_valido_3, resultado_aceito_3;

  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:    return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign ulaSaida   = alu(ulaControle, ulaEntrada1, ulaEntrada2);
  assign ulaZero    = (ulaSaida == 32'd0);
  assign ulaSaida_3 = alu(ulaControle_3, ulaEntrada1_3, ulaEntrada2_3);
  assign ulaZero_3  = (ulaSaida_3 == 32'd0);

  controle_ula #(.ESPERA_ULA(ESP)) u_dut (
    .clock(clock), .reset(reset), .instr_valido(instr_valido), .instr_pronto(instr_pronto),
    .opcode(opcode), .funct(funct), .regA(regA), .regB(regB), .imediato(imediato),
    .ulaEntrada1(ulaEntrada1), .ulaEntrada2(ulaEntrada2), .ulaControle(ulaControle),
    .ulaSaida(ulaSaida), .ulaZero(ulaZero), .resultado(resultado), .desvio(desvio),
    .erro(erro), .resultado_valido(resultado_valido), .resultado_aceito(resultado_aceito)
  );

  controle_ula #(.ESPERA_ULA(ESP3)) u_dut3 (
    .clock(clock), .reset(reset_3), .instr_valido(instr_valido_3), .instr_pronto(instr_pronto_3),
    .opcode(opcode_3), .funct(funct_3), .regA(regA_3), .regB(regB_3), .imediato(imediato_3),
    .ulaEntrada1(ulaEntrada1_3), .ulaEntrada2(ulaEntrada2_3), .ulaControle(ulaControle_3),
    .ulaSaida(ulaSaida_3), .ulaZero(ulaZero_3), .resultado(resultado_3), .desvio(desvio_3),
    .erro(erro_3), .resultado_valido(resultado_valido_3), .resultado_aceito(resultado_aceito_3)
  );

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] res;
    logic        desvio;
    logic        erro;
    logic [31:0] lat;
  } exp_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [7:0]  hold;
  } stim_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [3:0]  last_ctrl;
  logic [31:0] last_e1, last_e2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [31:0] b, input logic [15:0] imm,
                                     output logic legal, output logic [3:0] c,
                                     output logic [31:0] o2);
    logic [31:0] sx, zx;
    sx    = {{16{imm[15]}}, imm};
    zx    = {16'h0000, imm};
    legal = 1'b1;
    c     = 4'd0;
    o2    = b;
    case (op)
      6'h00: case (fn)
               6'h20:   c = 4'd2;
               6'h22:   c = 4'd3;
               6'h24:   c = 4'd0;
               6'h25:   c = 4'd1;
               6'h2A:   c = 4'd4;
               6'h27:   c = 4'd5;
               default: legal = 1'b0;
             endcase
      6'h08:        begin c = 4'd2; o2 = sx; end
      6'h0A:        begin c = 4'd4; o2 = sx; end
      6'h0C:        begin c = 4'd0; o2 = zx; end
      6'h0D:        begin c = 4'd1; o2 = zx; end
      6'h23, 6'h2B: begin c = 4'd2; o2 = sx; end
      6'h04, 6'h05: begin c = 4'd3; o2 = b;  end
      default:      legal = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    last_ctrl = 4'd0;
    last_e1   = '0;
    last_e2   = '0;
  endtask

  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                      input logic [31:0] b, input logic [15:0] imm);
    exp_t        e;
    logic        legal;
    logic [3:0]  c;
    logic [31:0] o2;
    int unsigned guard = 0;
    @(negedge clock);
    while (!instr_pronto && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!instr_pronto) check_eq("pronto_timeout", 32'(instr_pronto), 32'd1);
    opcode = op; funct = fn; regA = a; regB = b; imediato = imm;
    instr_valido = 1'b1;
    ref_decode(op, fn, b, imm, legal, c, o2);
    if (legal) begin
      e.ctrl   = c;
      e.e1     = a;
      e.e2     = o2;
      e.res    = alu(c, a, o2);
      e.desvio = (op == 6'h04) ? (e.res == 0) : (op == 6'h05) ? (e.res != 0) : 1'b0;
      e.erro   = 1'b0;
      e.lat    = 32'(1 + ESP);
      last_ctrl = c; last_e1 = a; last_e2 = o2;
    end else begin
      e.ctrl   = last_ctrl;
      e.e1     = last_e1;
      e.e2     = last_e2;
      e.res    = '0;
      e.desvio = 1'b0;
      e.erro   = 1'b1;
      e.lat    = 32'd1;
    end
    sb.push_back(e);
    @(posedge clock);
    #1 instr_valido = 1'b0;
  endtask

  // Waits for the response, compares it, applies backpressure for 'hold' cycles, then accepts.
  task automatic wait_resp(input int unsigned hold);
    exp_t        e;
    int unsigned n = 0;
    logic        got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clock);
      #1;
      n++;
      got = resultado_valido;
    end
    if (!got || sb.size() == 0) begin
      check_eq("resp_timeout", 32'(resultado_valido), 32'd1);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    check_eq("latency",   32'(n), e.lat);
    check_eq("resultado", resultado, e.res);
    check_eq("desvio",    32'(desvio), 32'(e.desvio));
    check_eq("erro",      32'(erro), 32'(e.erro));
    check_eq("ctrl",      32'(ulaControle), 32'(e.ctrl));
    check_eq("entrada1",  ulaEntrada1, e.e1);
    check_eq("entrada2",  ulaEntrada2, e.e2);
    check_eq("pronto_in_resp", 32'(instr_pronto), 32'd0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clock);
      instr_valido = 1'b1;
      opcode = 6'h00; funct = 6'h22; regA = $urandom; regB = $urandom;
      @(posedge clock);
      #1;
      check_eq("hold_valid",  32'(resultado_valido), 32'd1);
      check_eq("hold_pronto", 32'(instr_pronto), 32'd0);
      check_eq("hold_res",    resultado, e.res);
      check_eq("hold_flags",  {30'd0, erro, desvio}, {30'd0, e.erro, e.desvio});
    end
    @(negedge clock);
    resultado_aceito = 1'b1;
    instr_valido = 1'b1;
    opcode = 6'h00; funct = 6'h20;
    @(posedge clock);
    #1;
    instr_valido = 1'b0;
    resultado_aceito = 1'b0;
    check_eq("post_accept_valid",  32'(resultado_valido), 32'd0);
    check_eq("post_accept_pronto", 32'(instr_pronto), 32'd1);
    check_eq("idle_ctrl_hold",     32'(ulaControle), 32'(e.ctrl));
  endtask

  stim_t tab [17] = '{
    '{6'h00, 6'h20, 32'd5,         32'd7,         16'h0000, 8'd5},
    '{6'h00, 6'h22, 32'd20,        32'd3,         16'h0000, 8'd0},
    '{6'h00, 6'h24, 32'hF0F01234,  32'h0FF0FFFF,  16'h0000, 8'd0},
    '{6'h00, 6'h25, 32'hF0F01234,  32'h0FF0FFFF,  16'h0000, 8'd0},
    '{6'h00, 6'h2A, 32'hFFFFFFFF,  32'd1,         16'h0000, 8'd0},
    '{6'h00, 6'h27, 32'hF0F01234,  32'h0FF0FFFF,  16'h0000, 8'd0},
    '{6'h08, 6'h20, 32'd10,        32'h0000DEAD,  16'hFFFF, 8'd0},
    '{6'h0A, 6'h20, 32'hFFFF63C0,  32'h0000DEAD,  16'h8000, 8'd0},
    '{6'h0C, 6'h20, 32'h12345678,  32'h0000DEAD,  16'hFFFF, 8'd0},
    '{6'h0D, 6'h20, 32'd0,         32'h0000DEAD,  16'h8001, 8'd1},
    '{6'h23, 6'h20, 32'h00001000,  32'h0000DEAD,  16'hFFFC, 8'd0},
    '{6'h2B, 6'h20, 32'h00001000,  32'h0000DEAD,  16'h0010, 8'd0},
    '{6'h04, 6'h00, 32'h00000010,  32'h00000010,  16'h0001, 8'd0},
    '{6'h05, 6'h00, 32'h00000010,  32'h00000010,  16'h0001, 8'd0},
    '{6'h05, 6'h00, 32'h00000010,  32'h00000011,  16'h0001, 8'd0},
    '{6'h3F, 6'h00, 32'd1,         32'd2,         16'h0000, 8'd0},
    '{6'h00, 6'h01, 32'd1,         32'd2,         16'h0000, 8'd2}
  };

  initial begin
    exp_t        e;
    int unsigned n;
    int unsigned nvalid;
    logic        got;

    reset = 1'b1; instr_valido = 1'b0; resultado_aceito = 1'b0;
    opcode = '0; funct = '0; regA = '0; regB = '0; imediato = '0;
    reset_3 = 1'b1; instr_valido_3 = 1'b0; resultado_aceito_3 = 1'b0;
    opcode_3 = '0; funct_3 = '0; regA_3 = '0; regB_3 = '0; imediato_3 = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_pronto", 32'(instr_pronto), 32'd1);
    check_eq("rst_valid",  32'(resultado_valido), 32'd0);
    check_eq("rst_res",    resultado, 32'd0);
    check_eq("rst_flags",  {30'd0, erro, desvio}, 32'd0);
    check_eq("rst_ctrl",   32'(ulaControle), 32'd0);
    check_eq("rst_e1",     ulaEntrada1, 32'd0);
    check_eq("rst_e2",     ulaEntrada2, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    reset_3 = 1'b0;

    foreach (tab[i]) begin
      send(tab[i].op, tab[i].fn, tab[i].a, tab[i].b, tab[i].imm);
      wait_resp(int'(tab[i].hold));
    end

    // resultado_aceito held high while idle and executing must not disturb the flow
    @(negedge clock);
    resultado_aceito = 1'b1;
    send(6'h00, 6'h25, 32'h00FF0000, 32'h000000FF, 16'h0000);
    wait_resp(0);

    // reset wins over a simultaneous handshake
    @(negedge clock);
    instr_valido = 1'b1; opcode = 6'h00; funct = 6'h20; regA = 32'd9; regB = 32'd9;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    instr_valido = 1'b0;
    model_reset();
    check_eq("rstpri_pronto", 32'(instr_pronto), 32'd1);
    check_eq("rstpri_ctrl",   32'(ulaControle), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check_eq("rstpri_no_resp", 32'(resultado_valido), 32'd0);

    // reset while a response is pending clears it
    send(6'h00, 6'h20, 32'd1, 32'd2, 16'h0000);
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clock);
      #1;
      n++;
      got = resultado_valido;
    end
    e = sb.pop_front();
    check_eq("pre_rst_res", resultado, e.res);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check_eq("rstresp_valid", 32'(resultado_valido), 32'd0);
    check_eq("rstresp_res",   resultado, 32'd0);
    check_eq("rstresp_e1",    ulaEntrada1, 32'd0);

    send(6'h00, 6'h22, 32'd100, 32'd1, 16'h0000);
    wait_resp(0);

    // ESPERA_ULA = 3: normal latency, then an instruction abandoned by reset
    @(negedge clock);
    instr_valido_3 = 1'b1; opcode_3 = 6'h00; funct_3 = 6'h20; regA_3 = 32'd3; regB_3 = 32'd4;
    @(posedge clock);
    #1 instr_valido_3 = 1'b0;
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clock);
      #1;
      n++;
      got = resultado_valido_3;
    end
    check_eq("d3_latency", 32'(n), 32'(1 + ESP3));
    check_eq("d3_res",     resultado_3, 32'd7);
    @(negedge clock);
    resultado_aceito_3 = 1'b1;
    @(posedge clock);
    #1 resultado_aceito_3 = 1'b0;
    check_eq("d3_pronto", 32'(instr_pronto_3), 32'd1);

    @(negedge clock);
    instr_valido_3 = 1'b1; opcode_3 = 6'h00; funct_3 = 6'h22; regA_3 = 32'd9; regB_3 = 32'd2;
    @(posedge clock);
    #1 instr_valido_3 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("d3_inflight_ctrl", 32'(ulaControle_3), 32'd3);
    @(negedge clock);
    reset_3 = 1'b1;
    @(posedge clock);
    #1 reset_3 = 1'b0;
    check_eq("d3_abort_pronto", 32'(instr_pronto_3), 32'd1);
    check_eq("d3_abort_valid",  32'(resultado_valido_3), 32'd0);
    nvalid = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (resultado_valido_3) nvalid++;
    end
    check_eq("d3_no_resp", 32'(nvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
